// File: rtl/hypertape_port.sv
// Z80-side I/O responder for fast tape LOAD/SAVE: a four-register window
// (STATUS, DATA, CTRL, COUNT) backed by an RX FIFO (host->CPU) and a TX FIFO (CPU->host).
module hypertape_port #(
   parameter logic [15:0] BASE     = 16'h2040,
   parameter int unsigned DEPTH_LG = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [7:0]  d,
   input  logic        rd,
   input  logic        wr,
   output logic [7:0]  q,
   output logic        sel,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        load_req,
   output logic        save_req
);

   localparam int unsigned PW    = DEPTH_LG + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LG;

   typedef enum logic [1:0] {IDLE, LOAD, SAVE, FLUSH} state_t;

   state_t         state, state_n;
   logic [7:0]     rx_mem [DEPTH];
   logic [7:0]     tx_mem [DEPTH];
   logic [PW-1:0]  rx_w, rx_r, tx_w, tx_r;
   logic [PW-1:0]  rx_w_n, rx_r_n, tx_w_n, tx_r_n;
   logic           eof, ovf, eof_n, ovf_n;
   logic [7:0]     count, count_n, q_n, status, out_data_n;
   logic           in_ready_n, out_valid_n;
   logic [15:0]    off;
   logic [1:0]     idx;
   logic           rx_empty, rx_full, tx_empty, tx_full;
   logic           data_rd, data_wr, ctrl_wr;
   logic           start_load, start_save, stop;
   logic           rx_push, rx_pop, tx_push, tx_pop, tx_ovf, rd_ovf;

   // Pointers carry one wrap bit beyond the index.
   function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
      return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
   endfunction

   assign off = a - BASE;
   assign sel = (off < 16'd4);
   assign idx = off[1:0];

   assign rx_empty = (rx_w == rx_r);
   assign rx_full  = is_full(rx_w, rx_r);
   assign tx_empty = (tx_w == tx_r);
   assign tx_full  = is_full(tx_w, tx_r);

   assign data_rd = rd && sel && (idx == 2'd1);
   assign data_wr = wr && sel && (idx == 2'd1);
   assign ctrl_wr = wr && sel && (idx == 2'd2);

   // START_LOAD has priority over START_SAVE; only STOP is honoured outside IDLE.
   assign start_load = ctrl_wr && (state == IDLE) && d[0];
   assign start_save = ctrl_wr && (state == IDLE) && d[1] && !d[0];
   assign stop       = ctrl_wr && d[2] && ((state == LOAD) || (state == SAVE));

   assign rx_push = in_valid && in_ready;
   assign rx_pop  = data_rd && (state == LOAD) && !rx_empty;
   assign rd_ovf  = data_rd && (state == LOAD) && rx_empty;
   assign tx_pop  = out_valid && out_ready;
   assign tx_push = data_wr && (state == SAVE) && (!tx_full || tx_pop);
   assign tx_ovf  = data_wr && (state == SAVE) && tx_full && !tx_pop;

   assign status = {ovf, 2'b00, save_req, load_req, eof, tx_full, !rx_empty};

   // Next-state and next-output values for the registered block below.
   always_comb begin
      state_n = state;
      rx_w_n  = rx_w + PW'(rx_push);
      rx_r_n  = rx_r + PW'(rx_pop);
      tx_w_n  = tx_w + PW'(tx_push);
      tx_r_n  = tx_r + PW'(tx_pop);
      eof_n   = eof;
      ovf_n   = ovf;
      count_n = count + 8'(rx_pop || tx_push);
      q_n     = q;

      case (state)
         IDLE:    if (start_load) state_n = LOAD;
                  else if (start_save) state_n = SAVE;
         LOAD:    if (stop) state_n = IDLE;
         SAVE:    if (stop) state_n = FLUSH;
         FLUSH:   if (tx_empty) state_n = IDLE;
         default: state_n = IDLE;
      endcase

      if (start_load || (stop && (state == LOAD))) begin
         rx_w_n = '0;
         rx_r_n = '0;
      end
      if (start_save) begin
         tx_w_n = '0;
         tx_r_n = '0;
      end
      if (start_load || start_save) count_n = 8'h00;

      if (rx_push && in_last) eof_n = 1'b1;
      if (tx_ovf || rd_ovf)   ovf_n = 1'b1;
      if (start_load) begin
         eof_n = 1'b0;
         ovf_n = 1'b0;
      end

      if (rd && sel) begin
         case (idx)
            2'd0:    q_n = status;
            2'd1:    q_n = rx_pop ? rx_mem[rx_r[DEPTH_LG-1:0]] : 8'hFF;
            2'd2:    q_n = 8'h00;
            default: q_n = count;
         endcase
      end

      in_ready_n  = (state_n == LOAD) && !eof_n && !is_full(rx_w_n, rx_r_n);
      out_valid_n = (tx_w_n != tx_r_n);
      // A byte pushed into the slot that becomes the head is not in tx_mem yet.
      if (tx_push && (tx_w[DEPTH_LG-1:0] == tx_r_n[DEPTH_LG-1:0]))
         out_data_n = d;
      else
         out_data_n = tx_mem[tx_r_n[DEPTH_LG-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rx_w      <= '0;
         rx_r      <= '0;
         tx_w      <= '0;
         tx_r      <= '0;
         eof       <= 1'b0;
         ovf       <= 1'b0;
         count     <= 8'h00;
         q         <= 8'h00;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         load_req  <= 1'b0;
         save_req  <= 1'b0;
      end else begin
         state     <= state_n;
         rx_w      <= rx_w_n;
         rx_r      <= rx_r_n;
         tx_w      <= tx_w_n;
         tx_r      <= tx_r_n;
         eof       <= eof_n;
         ovf       <= ovf_n;
         count     <= count_n;
         q         <= q_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         out_data  <= out_data_n;
         load_req  <= (state_n == LOAD);
         save_req  <= (state_n == SAVE) || (state_n == FLUSH);
      end
   end

   // FIFO storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_w[DEPTH_LG-1:0]] <= in_data;
      if (tx_push) tx_mem[tx_w[DEPTH_LG-1:0]] <= d;
   end

endmodule

// File: tb/tb_hypertape_port.sv
// Directed plus randomized bench for hypertape_port, checked every cycle against a
// queue-based reference model of the register window and both FIFOs.
module tb_hypertape_port;

   localparam logic [15:0] BASE  = 16'h2040;
   localparam int          DEPTH = 16;

   logic        clk, rst_n;
   logic [15:0] a;
   logic [7:0]  d, q, in_data, out_data;
   logic        rd, wr, sel, in_last, in_valid, in_ready, out_valid, out_ready;
   logic        load_req, save_req;

   hypertape_port #(.BASE(BASE), .DEPTH_LG(4)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .d(d), .rd(rd), .wr(wr), .q(q), .sel(sel),
      .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .load_req(load_req), .save_req(save_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: session flags, byte queues, sticky flags, counter, read latch.
   bit         m_load, m_save, m_flush, m_eof, m_ovf;
   logic [7:0] m_cnt, m_q;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [7:0] sent[$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_save = 0; m_flush = 0; m_eof = 0; m_ovf = 0;
      m_cnt = 8'h00; m_q = 8'h00;
      rxq.delete(); txq.delete();
   endtask

   function automatic bit m_in_ready();
      return m_load && !m_eof && (rxq.size() < DEPTH);
   endfunction

   // Apply one clock edge of CPU/host activity to the model (pre-edge values in).
   task automatic model_step();
      logic [15:0] offs;
      bit          hit, ld, sv, fl, pre_ir, pre_txne, pre_txfull, txpop;
      logic [1:0]  ix;
      logic [7:0]  stat;
      offs = a - BASE;
      hit  = (offs < 16'd4);
      ix   = offs[1:0];
      ld = m_load; sv = m_save; fl = m_flush;
      pre_ir     = m_in_ready();
      pre_txne   = (txq.size() != 0);
      pre_txfull = (txq.size() == DEPTH);
      stat  = {m_ovf, 2'b00, (sv || fl), ld, m_eof, pre_txfull, (rxq.size() != 0)};
      txpop = pre_txne && out_ready;

      if (rd && hit) begin
         case (ix)
            2'd0: m_q = stat;
            2'd1: if (ld && rxq.size() != 0) begin
                     m_q = rxq.pop_front();
                     m_cnt++;
                  end else begin
                     m_q = 8'hFF;
                     if (ld) m_ovf = 1;
                  end
            2'd2: m_q = 8'h00;
            default: m_q = m_cnt;
         endcase
      end
      if (in_valid && pre_ir) begin
         rxq.push_back(in_data);
         if (in_last) m_eof = 1;
      end
      if (txpop) void'(txq.pop_front());
      if (wr && hit && ix == 2'd1 && sv) begin
         if (!pre_txfull || txpop) begin
            txq.push_back(d);
            m_cnt++;
         end else m_ovf = 1;
      end
      if (wr && hit && ix == 2'd2) begin
         if (!ld && !sv && !fl) begin
            if (d[0]) begin
               m_load = 1; rxq.delete(); m_eof = 0; m_ovf = 0; m_cnt = 8'h00;
            end else if (d[1]) begin
               m_save = 1; txq.delete(); m_cnt = 8'h00;
            end
         end else if (d[2]) begin
            if (ld) begin
               m_load = 0; rxq.delete();
            end else if (sv) begin
               m_save = 0; m_flush = 1;
            end
         end
      end
      if (fl && !pre_txne) m_flush = 0;
   endtask

   task automatic compare_all();
      logic [15:0] offs;
      offs = a - BASE;
      check("sel", 8'(sel), 8'(offs < 16'd4));
      check("q", q, m_q);
      check("in_ready", 8'(in_ready), 8'(m_in_ready()));
      check("out_valid", 8'(out_valid), 8'(txq.size() != 0));
      if (txq.size() != 0) check("out_data", out_data, txq[0]);
      check("load_req", 8'(load_req), 8'(m_load));
      check("save_req", 8'(save_req), 8'(m_save || m_flush));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic cpu_write(input logic [1:0] r, input logic [7:0] v);
      a = BASE + 16'(r); d = v; wr = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] r);
      a = BASE + 16'(r); rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic host_send(input logic [7:0] v, input logic last);
      in_data = v; in_last = last; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; a = 16'h0000; d = 8'h00; rd = 0; wr = 0;
      in_data = 8'h00; in_last = 0; in_valid = 0; out_ready = 0;
      model_reset();

      // Reset state
      repeat (2) tick();
      check("rst_q", q, 8'h00);
      check("rst_load_req", 8'(load_req), 8'h00);
      check("rst_in_ready", 8'(in_ready), 8'h00);
      @(negedge clk); rst_n = 1'b1;
      cpu_read(2'd0);
      check("status_after_reset", q, 8'h00);

      // Load of three bytes, last one tagged
      cpu_write(2'd2, 8'h01);
      host_send(8'h11, 1'b0);
      host_send(8'h22, 1'b0);
      host_send(8'h33, 1'b1);
      cpu_read(2'd1); check("load_b0", q, 8'h11);
      cpu_read(2'd1); check("load_b1", q, 8'h22);
      cpu_read(2'd1); check("load_b2", q, 8'h33);
      cpu_read(2'd0); check("load_status_eof", q, 8'h0C);
      cpu_read(2'd3); check("load_count", q, 8'h03);
      check("load_in_ready_after_eof", 8'(in_ready), 8'h00);
      cpu_read(2'd2); check("ctrl_reads_zero", q, 8'h00);

      // Underflow while the host is stalled
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h01);
      cpu_read(2'd1); check("underflow_ff", q, 8'hFF);
      cpu_read(2'd0); check("underflow_status", q, 8'h88);

      // Save with the host stalled: 17th byte overflows
      cpu_write(2'd2, 8'h04);
      cpu_write(2'd2, 8'h02);
      sent.delete();
      for (int i = 0; i < 17; i++) begin
         sent.push_back(8'(i * 13 + 5));
         cpu_write(2'd1, 8'(i * 13 + 5));
      end
      cpu_read(2'd0); check("save_status_full_ovf", q, 8'h92);
      cpu_read(2'd3); check("save_count", q, 8'h10);

      // Flush: 16 bytes out one per clock, then save_req drops a clock later
      cpu_write(2'd2, 8'h04);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("flush_valid", 8'(out_valid), 8'h01);
         check("flush_byte", out_data, sent[i]);
         tick();
      end
      check("flush_empty", 8'(out_valid), 8'h00);
      check("flush_save_req_held", 8'(save_req), 8'h01);
      tick();
      check("flush_save_req_fall", 8'(save_req), 8'h00);
      out_ready = 1'b0;

      // Asynchronous reset in the middle of a load with five bytes queued
      cpu_write(2'd2, 8'h01);
      for (int i = 0; i < 5; i++) host_send(8'(8'hA0 + i), 1'b0);
      cpu_read(2'd0); check("pre_reset_status", q, 8'h09);
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("async_q", q, 8'h00);
      check("async_in_ready", 8'(in_ready), 8'h00);
      check("async_load_req", 8'(load_req), 8'h00);
      check("async_save_req", 8'(save_req), 8'h00);
      check("async_out_valid", 8'(out_valid), 8'h00);
      model_reset();
      tick();
      @(negedge clk); rst_n = 1'b1;
      cpu_read(2'd0); check("status_after_async_reset", q, 8'h00);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int op;
         logic [7:0] cv [5];
         cv[0] = 8'h01; cv[1] = 8'h02; cv[2] = 8'h04; cv[3] = 8'h03; cv[4] = 8'h06;
         op = int'($urandom_range(0, 19));
         rd = 0; wr = 0;
         if (op < 6) begin
            rd = 1;
            a  = BASE + 16'($urandom_range(0, 3));
            if (op == 0) a = BASE + 16'd4;
         end else if (op < 10) begin
            wr = 1; a = BASE + 16'd1; d = 8'($urandom);
            if (op == 6) a = BASE - 16'd1;
         end else if (op == 10) begin
            wr = 1; a = BASE + 16'd2; d = cv[$urandom_range(0, 4)];
         end else begin
            a = BASE + 16'($urandom_range(0, 5)) - 16'd1;
         end
         in_valid  = ($urandom_range(0, 1) == 1);
         in_last   = ($urandom_range(0, 9) == 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      rd = 0; wr = 0; in_valid = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
